// File: rtl/iob_native_split.sv
// CPU native-port to N-channel IOb splitter: one outstanding request, routed by address MSBs.
// Latency: write 2 cycles, read 3 cycles minimum; unmapped or timed-out accesses return err; cke_i=0 freezes everything.
module iob_native_split #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int N_SLAVES  = 2,
  parameter int SEL_W     = 1,
  parameter int TIMEOUT_W = 8
) (
  input  logic                       clk_i,
  input  logic                       arst_n_i,
  input  logic                       cke_i,
  input  logic                       nat_valid_i,
  input  logic [ADDR_W-1:0]          nat_addr_i,
  input  logic [DATA_W-1:0]          nat_wdata_i,
  input  logic [DATA_W/8-1:0]        nat_wstrb_i,
  output logic                       nat_ready_o,
  output logic [DATA_W-1:0]          nat_rdata_o,
  output logic                       nat_err_o,
  output logic [N_SLAVES-1:0]        iob_avalid_o,
  output logic [ADDR_W-1:0]          iob_addr_o,
  output logic [DATA_W-1:0]          iob_wdata_o,
  output logic [DATA_W/8-1:0]        iob_wstrb_o,
  input  logic [N_SLAVES*DATA_W-1:0] iob_rdata_i,
  input  logic [N_SLAVES-1:0]        iob_rvalid_i,
  input  logic [N_SLAVES-1:0]        iob_ready_i
);

  localparam int WSTRB_W = DATA_W / 8;
  localparam int SW      = (N_SLAVES > 1) ? SEL_W : 1;
  localparam int CNT_W   = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - 1'b1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [WSTRB_W-1:0]  wstrb_q, wstrb_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [SW-1:0]       sel;
  logic                sel_ok;
  logic                timeout;
  logic                rdy_sel;
  logic                rvld_sel;
  logic [DATA_W-1:0]   rdata_sel;

  if (N_SLAVES == 1) begin : g_single
    assign sel = '0;
  end else begin : g_multi
    assign sel = nat_addr_i[ADDR_W-1 -: SW];
  end

  assign sel_ok = (int'(sel) < N_SLAVES);

  // The counter saturates, so a read that only reached WAIT_R on the terminal
  // cycle still gets exactly one more cycle for its rvalid before erroring.
  if (TIMEOUT_W > 0) begin : g_timeout
    assign timeout = (cnt_q >= CNT_LAST);
  end else begin : g_no_timeout
    assign timeout = 1'b0;
  end

  always_comb begin
    rdy_sel   = 1'b0;
    rvld_sel  = 1'b0;
    rdata_sel = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel_q == SW'(k)) begin
        rdy_sel   = iob_ready_i[k];
        rvld_sel  = iob_rvalid_i[k];
        rdata_sel = iob_rdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (nat_valid_i) begin
          addr_d  = nat_addr_i;
          wdata_d = nat_wdata_i;
          wstrb_d = nat_wstrb_i;
          sel_d   = sel;
          cnt_d   = '0;
          if (sel_ok) begin
            state_d = REQ;
            err_d   = 1'b0;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      REQ: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (rdy_sel) begin
          if (|wstrb_q) begin
            state_d = RESP;
            rdata_d = '0;
          end else begin
            state_d = WAIT_R;
          end
        end else if (timeout) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      WAIT_R: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (rvld_sel) begin
          state_d = RESP;
          rdata_d = rdata_sel;
        end else if (timeout) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    iob_avalid_o = '0;
    if (state_q == REQ) begin
      for (int k = 0; k < N_SLAVES; k++) begin
        iob_avalid_o[k] = (sel_q == SW'(k));
      end
    end
  end

  assign nat_ready_o = (state_q == RESP);
  assign nat_err_o   = nat_ready_o & err_q;
  assign nat_rdata_o = rdata_q;
  assign iob_addr_o  = addr_q;
  assign iob_wdata_o = wdata_q;
  assign iob_wstrb_o = wstrb_q;

endmodule
